display_mux_7seg_hhmmss: RTL

//  Time-multiplexed driver for a 6-digit common-anode 7-segment display.

---
 rtl/display_mux_7seg_hhmmss.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/display_mux_7seg_hhmmss.sv
// Six-digit multiplexed 7-segment driver for an hh.mm.ss clock.
// Scans one digit per refresh slot, decodes BCD to segments, and blinks
// the field selected for editing by en_count.
module display_mux_7seg_hhmmss #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en_count,
  input  logic [3:0] hh1,
  input  logic [3:0] hh0,
  input  logic [3:0] mm1,
  input  logic [3:0] mm0,
  input  logic [3:0] ss1,
  input  logic [3:0] ss0,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  typedef enum logic {VISIBLE, HIDDEN} phase_t;

  logic [RW-1:0] refresh_cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_d;
  phase_t        phase_q;
  phase_t        phase_d;
  logic [3:0]    en_prev;

  logic          refresh_tc_c;
  logic          blink_tc_c;
  logic          en_changed_c;
  logic [3:0]    digit_c;
  logic          selected_c;
  logic          hide_c;
  logic [5:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign refresh_tc_c = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign blink_tc_c   = (blink_cnt == BW'(BLINK_DIV - 1));
  assign en_changed_c = (en_count != en_prev);

  // Refresh counter and digit index; index wraps 5 -> 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= 3'd0;
    end else if (refresh_tc_c) begin
      refresh_cnt <= '0;
      idx         <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blink phase state register, counter and previous field select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= VISIBLE;
      blink_cnt <= '0;
      en_prev   <= 4'd0;
    end else begin
      phase_q   <= phase_d;
      blink_cnt <= blink_cnt_d;
      en_prev   <= en_count;
    end
  end

  // Blink next state: a select change restarts the blink in the visible phase
  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt + BW'(1);
    if (en_changed_c) begin
      phase_d     = VISIBLE;
      blink_cnt_d = '0;
    end else if (blink_tc_c) begin
      blink_cnt_d = '0;
      phase_d     = (phase_q == VISIBLE) ? HIDDEN : VISIBLE;
    end
  end

  // Digit select, field blanking and BCD decode for the active slot
  always_comb begin
    digit_c    = 4'd0;
    selected_c = 1'b0;
    seg_d      = 7'b1111111;
    case (idx)
      3'd0:    digit_c = ss0;
      3'd1:    digit_c = ss1;
      3'd2:    digit_c = mm0;
      3'd3:    digit_c = mm1;
      3'd4:    digit_c = hh0;
      3'd5:    digit_c = hh1;
      default: digit_c = 4'd0;
    endcase
    case (en_count)
      4'd1:    selected_c = (idx[2:1] == 2'd2);
      4'd2:    selected_c = (idx[2:1] == 2'd1);
      4'd4:    selected_c = (idx[2:1] == 2'd0);
      default: selected_c = 1'b0;
    endcase
    // a freshly selected field must show at once, even if the old phase was hidden
    hide_c = (phase_q == HIDDEN) && selected_c && !en_changed_c;
    case (digit_c)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    an_d = hide_c ? 6'b111111 : ~(6'b000001 << idx);
    dp_d = hide_c ? 1'b1 : !((idx == 3'd2) || (idx == 3'd4));
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 6'b111111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
